doc_uart_sender: RTL and testbench



---
 rtl/doc_pkg.sv | 34 +++
 rtl/doc_scan_counter.sv | 57 +++++
 rtl/doc_uart_sender.sv | 140 ++++++++++++++
 tb/tb_doc_uart_sender.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : doc_pkg
//  Description : Shared definitions for the document path: UART sender state
//                encoding, grid geometry defaults, special characters and
//                the {row, col} address packing used by editor/VGA/UART.
//  Revision    : 1.0  initial release
// ============================================================================
package doc_pkg;

    localparam int          DEF_ROWS       = 15;
    localparam int          DEF_COLS       = 20;
    localparam int          ROW_W          = 4;
    localparam int          COL_W          = 5;
    localparam int          ADDR_W         = ROW_W + COL_W;
    localparam logic [7:0]  DEF_NL_CHAR    = 8'h0A;
    localparam logic [7:0]  DEF_BLANK_CHAR = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_SEND    = 3'd2,
        ST_NEWLINE = 3'd3,
        ST_CLEAR   = 3'd4
    } sender_state_t;

    // Document address is row in the upper bits, column in the lower bits.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/doc_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : doc_scan_counter
//  Description : Row/column scan position for the document transmit. Column
//                advances on inc_col, next_row moves to column 0 of the next
//                row, clr returns to the origin. Both counters saturate.
//  Revision    : 1.0  initial release
// ============================================================================
module doc_scan_counter
    import doc_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_col,
    input  logic             next_row,
    input  logic             clr,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last_col,
    output logic             last_row
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;

    // Position flags used by the FSM to decide on line feed / final byte.
    always_comb begin
        last_col = (r_col == COL_W'(COLS - 1));
        last_row = (r_row == ROW_W'(ROWS - 1));
    end

    // Scan position registers; increments are blocked at the last index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (next_row) begin
            if (!last_row) begin
                r_row <= r_row + ROW_W'(1);
                r_col <= '0;
            end
        end else if (inc_col && !last_col) begin
            r_col <= r_col + COL_W'(1);
        end
    end

    assign row = r_row;
    assign col = r_col;

endmodule
`default_nettype wire

// File: rtl/doc_uart_sender.sv
`default_nettype none
// ============================================================================
//  Module      : doc_uart_sender
//  Description : Streams the whole document grid to a UART transmitter one
//                byte per valid/ready handshake, a line feed after each row,
//                then pulses clear_data once the final byte is accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module doc_uart_sender
    import doc_pkg::*;
#(
    parameter int         ROWS       = DEF_ROWS,
    parameter int         COLS       = DEF_COLS,
    parameter logic [7:0] NL_CHAR    = DEF_NL_CHAR,
    parameter logic [7:0] BLANK_CHAR = DEF_BLANK_CHAR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        read_enable,
    output logic [8:0]  read_addr,
    input  logic [7:0]  read_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        clear_data
);

    sender_state_t    r_state;
    sender_state_t    w_next;
    logic [7:0]       r_tx_data;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_inc_col;
    logic             w_next_row;
    logic             w_clr;
    logic             w_hs;

    doc_scan_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_col  (w_inc_col),
        .next_row (w_next_row),
        .clr      (w_clr),
        .row      (w_row),
        .col      (w_col),
        .last_col (w_last_col),
        .last_row (w_last_row)
    );

    // A byte is accepted only in the two states that present one.
    assign w_hs = ((r_state == ST_SEND) || (r_state == ST_NEWLINE)) && tx_ready;

    // State register; reset aborts a transfer with no clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Capture the cell in READ so the byte stays stable through backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data <= '0;
        end else if (r_state == ST_READ) begin
            r_tx_data <= (read_data == 8'h00) ? BLANK_CHAR : read_data;
        end
    end

    // Next-state and scan-counter control.
    always_comb begin
        w_next     = r_state;
        w_inc_col  = 1'b0;
        w_next_row = 1'b0;
        w_clr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clr = 1'b1;
                if (start) w_next = ST_READ;
            end
            ST_READ: w_next = ST_SEND;
            ST_SEND: begin
                if (w_hs) begin
                    if (w_last_col) begin
                        w_next = ST_NEWLINE;
                    end else begin
                        w_inc_col = 1'b1;
                        w_next    = ST_READ;
                    end
                end
            end
            ST_NEWLINE: begin
                if (w_hs) begin
                    if (w_last_row) begin
                        w_next = ST_CLEAR;
                    end else begin
                        w_next_row = 1'b1;
                        w_next     = ST_READ;
                    end
                end
            end
            ST_CLEAR: begin
                w_clr  = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_clr  = 1'b1;
                w_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; IDLE drives everything to zero.
    always_comb begin
        read_enable = 1'b0;
        read_addr   = '0;
        tx_data     = '0;
        tx_valid    = 1'b0;
        busy        = (r_state != ST_IDLE);
        clear_data  = (r_state == ST_CLEAR);
        if ((r_state == ST_READ) || (r_state == ST_SEND) || (r_state == ST_NEWLINE)) begin
            read_enable = 1'b1;
            read_addr   = pack_addr(w_row, w_col);
        end
        if (r_state == ST_SEND) begin
            tx_valid = 1'b1;
            tx_data  = r_tx_data;
        end else if (r_state == ST_NEWLINE) begin
            tx_valid = 1'b1;
            tx_data  = NL_CHAR;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_doc_uart_sender.sv
`default_nettype none
// ============================================================================
//  Module      : tb_doc_uart_sender
//  Description : Scoreboard bench for doc_uart_sender with a behavioural
//                document RAM and a UART-side monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_doc_uart_sender;

    localparam int BYTES  = 315;
    localparam int BUDGET = 3000;

    typedef struct packed {
        logic [7:0] data;
        logic [8:0] addr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       tx_ready = 1'b1;
    logic       read_enable;
    logic [8:0] read_addr;
    logic [7:0] read_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       clear_data;

    logic [7:0] doc [0:511];
    exp_t       exp_q [$];
    logic [7:0] rx_q [$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         clear_cnt = 0;
    int         total_hs = 0;
    int         cyc = 0;
    int         last_hs_cyc = -10;

    doc_uart_sender dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .read_enable (read_enable),
        .read_addr   (read_addr),
        .read_data   (read_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .clear_data  (clear_data)
    );

    always #5 clk = ~clk;

    // Combinational document read port
    assign read_data = doc[read_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // UART-side monitor: pops the scoreboard on every accepted byte
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && tx_valid && tx_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_byte: got data %h addr %h, none expected", tx_data, read_addr);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e.data || read_addr !== e.addr)
                    $display("FAIL byte_%0d: got data %h addr %h, expected data %h addr %h",
                             rx_q.size(), tx_data, read_addr, e.data, e.addr);
                else
                    n_pass++;
            end
            rx_q.push_back(tx_data);
            total_hs++;
            last_hs_cyc = cyc;
        end
        if (rst_n && clear_data) begin
            clear_cnt++;
            n_checks++;
            if (last_hs_cyc != cyc - 1 || exp_q.size() != 0)
                $display("FAIL clear_timing: last handshake cycle %0d clear cycle %0d pending %0d, expected %0d and 0",
                         last_hs_cyc, cyc, exp_q.size(), cyc - 1);
            else
                n_pass++;
        end
    end

    // Expected stream for the current document contents
    task automatic push_run();
        logic [8:0] a;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                a = {r[3:0], c[4:0]};
                exp_q.push_back('{data: (doc[a] == 8'h00) ? 8'h20 : doc[a], addr: a});
            end
            exp_q.push_back('{data: 8'h0A, addr: {r[3:0], 5'd19}});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_clear(input int base, output bit ok);
        for (int i = 0; i < BUDGET && clear_cnt == base; i++) begin
            @(posedge clk); #1;
        end
        ok = (clear_cnt != base);
    endtask

    task automatic wait_bytes(input int base, input int n, output bit ok);
        for (int i = 0; i < BUDGET && (total_hs - base) < n; i++) begin
            @(posedge clk); #1;
        end
        ok = ((total_hs - base) >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({read_enable, read_addr, tx_data, tx_valid, busy, clear_data} !== 21'd0)
            $display("FAIL reset_outputs: got re=%b addr=%h data=%h v=%b busy=%b clr=%b, expected all 0",
                     read_enable, read_addr, tx_data, tx_valid, busy, clear_data);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) $display("FAIL idle_after_reset: busy=%b valid=%b, expected 0 0", busy, tx_valid);
        else n_pass++;
    endtask

    task automatic test_empty_doc();
        int base_c;
        bit ok;
        for (int i = 0; i < 512; i++) doc[i] = 8'h00;
        tx_ready = 1'b1;
        rx_q.delete();
        base_c = clear_cnt;
        push_run();
        pulse_start();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || read_enable !== 1'b1 || tx_valid !== 1'b0)
            $display("FAIL start_latency1: busy=%b re=%b valid=%b, expected 1 1 0", busy, read_enable, tx_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (tx_valid !== 1'b1) $display("FAIL start_latency2: valid=%b, expected 1", tx_valid);
        else n_pass++;
        wait_clear(base_c, ok);
        n_checks++;
        if (!ok) $display("FAIL empty_timeout: clear_data not seen, expected a pulse");
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_fall: busy=%b, expected 0", busy);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rx_q.size() != BYTES || clear_cnt != base_c + 1)
            $display("FAIL empty_count: bytes=%0d clears=%0d, expected %0d and %0d", rx_q.size(), clear_cnt - base_c, BYTES, 1);
        else n_pass++;
    endtask

    task automatic test_pattern();
        int base_c;
        bit ok;
        for (int i = 0; i < 512; i++) doc[i] = 8'h00;
        doc[9'h000] = 8'h41;
        doc[{4'd14, 5'd19}] = 8'h5A;
        rx_q.delete();
        base_c = clear_cnt;
        push_run();
        pulse_start();
        wait_clear(base_c, ok);
        n_checks++;
        if (!ok || rx_q.size() != BYTES)
            $display("FAIL pattern_count: done=%b bytes=%0d, expected 1 and %0d", ok, rx_q.size(), BYTES);
        else n_pass++;
        if (rx_q.size() == BYTES) begin
            n_checks++;
            if (rx_q[0] !== 8'h41 || rx_q[313] !== 8'h5A || rx_q[314] !== 8'h0A)
                $display("FAIL pattern_bytes: got %h %h %h, expected 41 5a 0a", rx_q[0], rx_q[313], rx_q[314]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int base_c, base_h;
        bit ok;
        for (int i = 0; i < 512; i++) doc[i] = 8'h30 + 8'(i);
        rx_q.delete();
        base_c = clear_cnt;
        base_h = total_hs;
        push_run();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (tx_valid && (total_hs - base_h) == 3) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (!ok) $display("FAIL bp_reach: byte 3 never presented, expected it");
        else n_pass++;
        tx_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h33 || read_addr !== 9'h003)
                $display("FAIL bp_hold_%0d: valid=%b data=%h addr=%h, expected 1 33 003", k, tx_valid, tx_data, read_addr);
            else n_pass++;
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        wait_clear(base_c, ok);
        n_checks++;
        if (!ok || rx_q.size() != BYTES)
            $display("FAIL bp_count: done=%b bytes=%0d, expected 1 and %0d", ok, rx_q.size(), BYTES);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base_c, base_h;
        bit ok;
        for (int i = 0; i < 512; i++) doc[i] = 8'h00;
        doc[9'h000] = 8'h42;
        base_c = clear_cnt;
        base_h = total_hs;
        push_run();
        pulse_start();
        wait_bytes(base_h, 100, ok);
        n_checks++;
        if (!ok) $display("FAIL mid_reach: only %0d bytes, expected 100", total_hs - base_h);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({read_enable, read_addr, tx_data, tx_valid, busy, clear_data} !== 21'd0)
            $display("FAIL mid_reset_outputs: re=%b addr=%h data=%h v=%b busy=%b clr=%b, expected all 0",
                     read_enable, read_addr, tx_data, tx_valid, busy, clear_data);
        else n_pass++;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (clear_cnt != base_c || busy !== 1'b0)
            $display("FAIL mid_no_clear: clears=%0d busy=%b, expected 0 0", clear_cnt - base_c, busy);
        else n_pass++;
        rx_q.delete();
        push_run();
        pulse_start();
        wait_clear(base_c, ok);
        n_checks++;
        if (!ok || rx_q.size() != BYTES || clear_cnt != base_c + 1)
            $display("FAIL mid_restart: done=%b bytes=%0d clears=%0d, expected 1 %0d 1", ok, rx_q.size(), clear_cnt - base_c, BYTES);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int base_c, base_h;
        bit ok;
        for (int i = 0; i < 512; i++) doc[i] = 8'h61 + 8'(i % 26);
        rx_q.delete();
        base_c = clear_cnt;
        base_h = total_hs;
        push_run();
        pulse_start();
        wait_bytes(base_h, 50, ok);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            if (clear_data) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (!ok) $display("FAIL ign_clear_reach: clear_data not seen, expected a pulse");
        else n_pass++;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || rx_q.size() != BYTES || clear_cnt != base_c + 1 || exp_q.size() != 0)
            $display("FAIL ign_result: busy=%b bytes=%0d clears=%0d pending=%0d, expected 0 %0d 1 0",
                     busy, rx_q.size(), clear_cnt - base_c, exp_q.size(), BYTES);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) doc[i] = 8'h00;
        test_reset();
        test_empty_doc();
        test_pattern();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
